register_bank: RTL and testbench

Parametrised general-purpose register bank for the datapath: replaces the per-register instances on the bus with one block of NUM_REGS registers, one write port, two registered read ports, write-first bypass, optional hard-wired zero register and a sequenced bulk-zero operation. Sits between the bus (write data from BusMuxOut) and the ALU/bus-mux inputs (read data). It is the generalised successor of the single enable/clear register.

---
 rtl/register_bank.sv | 139 +++++++++++++
 tb/tb_register_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: NUM_REGS x DATA_WIDTH register file, one write port,
// two registered read ports with write-first bypass and a bulk-zero sweep.
module register_bank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           NUM_REGS   = 16,
  parameter bit                    R0_ZERO    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  zero_start,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_REGS - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0]   rd_b_q, rd_b_d;
  logic                    sweep;
  logic                    wr_ok;

  function automatic logic addr_ok(
    input logic [ADDR_WIDTH-1:0] a
  );
    addr_ok = (32'(a) < NUM_REGS) &&
              !(R0_ZERO && (a == '0));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_mux(
    input logic [ADDR_WIDTH-1:0] a
  );
    rd_mux = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (a == ADDR_WIDTH'(i)) rd_mux = regs_q[i];
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_next(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (wr_ok && (wr_addr == a))
      rd_next = wr_data;
    else if (sweep && (ptr_q == a))
      rd_next = '0;
    else if (addr_ok(a))
      rd_next = rd_mux(a);
    else
      rd_next = '0;
  endfunction

  assign sweep = (state_q == SWEEP);

  // Writes are only honoured while idle; the sweep owns the array.
  assign wr_ok = !sweep && wr_en && addr_ok(wr_addr);

  always_comb begin
    rd_a_d = rd_next(rd_addr_a);
    rd_b_d = rd_next(rd_addr_b);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (zero_start) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < int'(NUM_REGS); i++)
        regs_q[i] <= INIT;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (sweep && (ptr_q == ADDR_WIDTH'(i)))
          regs_q[i] <= '0;
        else if (wr_ok && (wr_addr == ADDR_WIDTH'(i)))
          regs_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: random + directed stimulus, scoreboard queue,
// edge-indexed reference model of the register bank.
module tb_register_bank;

  localparam int          N    = 16;
  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
  } exp_t;

  logic          clock = 1'b0;
  logic          clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          zero_start;
  logic          busy;

  exp_t          sb[$];
  logic [DW-1:0] m [N];
  int            e;
  int            ks;
  int            total;
  int            bad;

  register_bank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (N),
    .R0_ZERO    (1'b1),
    .INIT       (INIT)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .zero_start (zero_start),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    if (int'(a) < N && a != 0) return m[int'(a)];
    return '0;
  endfunction

  function automatic logic sweeping(input int edge_no);
    return ks >= 0 && edge_no > ks && edge_no <= ks + N;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = INIT;
    ks = -1;
  endtask

  // Drive one edge's inputs and queue what the outputs must be after it.
  task automatic step(input logic          we,
                      input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra,
                      input logic [AW-1:0] rb,
                      input logic          zs);
    exp_t x;
    @(negedge clock);
    clear      = 1'b1;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rd_addr_a  = ra;
    rd_addr_b  = rb;
    zero_start = zs;
    e++;
    if (sweeping(e)) begin
      m[e - ks - 1] = '0;
    end else begin
      if (we && int'(wa) < N && wa != 0) m[int'(wa)] = wd;
      if (zs) ks = e;
    end
    x.a    = mrd(ra);
    x.b    = mrd(rb);
    x.busy = ks >= 0 && e >= ks && e < ks + N;
    sb.push_back(x);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rd_a", rd_data_a, 32'd0);
    chk("rst_rd_b", rd_data_b, 32'd0);
    model_reset();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("rd_data_a", rd_data_a, x.a);
        chk("rd_data_b", rd_data_b, x.b);
        chk("busy", {31'b0, busy}, {31'b0, x.busy});
      end
    end
  end

  initial begin : driver
    logic          we;
    logic          zs;
    logic [AW-1:0] wa;
    total      = 0;
    bad        = 0;
    e          = 0;
    clear      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    zero_start = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rd_a", rd_data_a, 32'd0);
    chk("rst_rd_b", rd_data_b, 32'd0);

    step(0, 0, 0, 3, 0, 0);
    step(1, 5, 32'h12345678, 5, 5, 0);
    step(1, 0, 32'hFF, 0, 5, 0);
    step(1, 20, 32'hDEADBEEF, 20, 15, 0);
    step(0, 0, 0, 0, 20, 0);

    for (int i = 1; i < N; i++)
      step(1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 0);
    step(0, 0, 0, 9, 7, 1);
    for (int j = 1; j <= N; j++) begin
      if (j == 5) step(1, 7, 32'd77, 9, 7, 0);
      else        step(0, 0, 0, 9, 7, 0);
    end
    for (int i = 0; i < N; i++)
      step(0, 0, 0, AW'(i), AW'(i + N), 0);

    step(1, 9, 32'd99, 9, 3, 0);
    step(0, 0, 0, 9, 3, 1);
    for (int j = 1; j <= 6; j++) step(0, 0, 0, 9, 3, 0);
    async_reset();
    step(0, 0, 0, 9, 3, 1);
    for (int j = 1; j <= N + 1; j++) step(0, 0, 0, 9, 3, 1);
    step(0, 0, 0, 9, 3, 0);

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom);
      wa = AW'($urandom_range(0, 31));
      zs = ($urandom_range(0, 24) == 0);
      if (ks >= 0 && e + 1 == ks + N) we = 1'b0;
      step(we, wa, $urandom,
           AW'($urandom_range(0, 31)),
           AW'($urandom_range(0, 31)), zs);
    end

    step(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #3;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
